// File: rtl/icache_pkg.sv
// Shared types and constants for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REFILL   = 2'd1,
    ST_UNCACHED = 2'd2
  } state_e;

  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [31:0] KSEG1_MASK = 32'hE000_0000;
  localparam logic [1:0]  SIZE_WORD  = 2'b10;

  function automatic logic is_kseg1(input logic [31:0] addr);
    return (addr & KSEG1_MASK) == KSEG1_BASE;
  endfunction

endpackage

// File: rtl/icache_setassoc_plru_tree.sv
// Per-set tree pseudo-LRU state: bits point toward the least recently used side.
module plru_tree #(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  localparam int SW = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [SW-1:0] rd_set_i,
  output logic [WW-1:0] victim_o,
  input  logic          upd_en_i,
  input  logic [SW-1:0] upd_set_i,
  input  logic [WW-1:0] upd_way_i
);
  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;

  logic [PW-1:0] bits_q [SETS];
  logic [PW-1:0] rd_bits;
  logic [PW-1:0] new_bits;

  assign rd_bits = bits_q[rd_set_i];

  generate
    if (WAYS == 4) begin : g_four
      logic [PW-1:0] old_bits;
      assign old_bits = bits_q[upd_set_i];
      always_comb begin
        victim_o    = rd_bits[0] ? {1'b1, rd_bits[2]} : {1'b0, rd_bits[1]};
        new_bits    = old_bits;
        new_bits[0] = ~upd_way_i[1];
        if (upd_way_i[1]) new_bits[2] = ~upd_way_i[0];
        else              new_bits[1] = ~upd_way_i[0];
      end
    end else if (WAYS == 2) begin : g_two
      assign victim_o = rd_bits;
      assign new_bits = ~upd_way_i;
    end else begin : g_one
      logic unused_plru;
      assign unused_plru = ^{rd_bits, upd_way_i};
      assign victim_o    = '0;
      assign new_bits    = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
    end else if (upd_en_i) begin
      bits_q[upd_set_i] <= new_bits;
    end
  end

endmodule

// File: rtl/icache_setassoc.sv
// N-way set-associative instruction cache with word-serial refill and kseg1 bypass.
module icache_setassoc
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int WAYS         = 2,
  parameter bit UNCACHED_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);
  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << (OFFSET_WIDTH - 2);
  localparam int TAG_W      = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_W     = OFFSET_WIDTH - 2;
  localparam int WW         = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e                   state_q, state_d;
  logic [WORD_W-1:0]        cnt_q, cnt_d;
  logic                     wait_q, wait_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
  logic [WW-1:0]            victim_q, victim_d;

  logic [TAG_W-1:0]         cpu_tag;
  logic [INDEX_WIDTH-1:0]   cpu_idx;
  logic [WORD_W-1:0]        cpu_word;
  logic [WAYS-1:0]          hit_vec, way_valid;
  logic [31:0]              way_rdata [WAYS];
  logic                     hit_any;
  logic [WW-1:0]            hit_way, victim_sel, plru_victim, plru_way;
  logic [31:0]              hit_word;
  logic                     refill_we, refill_last, plru_upd, miss_inv;
  logic                     unused_in;

  assign cpu_tag          = cpu_inst_addr[31 -: TAG_W];
  assign cpu_idx          = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cpu_word         = cpu_inst_addr[2 +: WORD_W];
  assign cache_inst_wr    = 1'b0;
  assign cache_inst_wdata = 32'h0;
  assign unused_in        = ^{cpu_inst_wdata, cpu_inst_addr[1:0]};

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0] tag_mem [SETS];
      logic [31:0]      data_mem [SETS][LINE_WORDS];
      logic [SETS-1:0]  valid_q;
      logic             sel;
      assign sel = (victim_q == WW'(gi));

      always_ff @(posedge clk) begin
        if (refill_we && sel) data_mem[idx_q][cnt_q] <= cache_inst_rdata;
        if (refill_last && sel) tag_mem[idx_q] <= tag_q;
      end

      // The victim is invalidated at miss time so a stale tag never hits a half-rewritten line.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else if (refill_last && sel) valid_q[idx_q] <= 1'b1;
        else if (miss_inv && victim_sel == WW'(gi)) valid_q[cpu_idx] <= 1'b0;
      end

      assign way_valid[gi] = valid_q[cpu_idx];
      assign hit_vec[gi]   = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
      assign way_rdata[gi] = data_mem[cpu_idx][cpu_word];
    end
  endgenerate

  always_comb begin
    hit_way  = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) begin
        hit_way  = WW'(w);
        hit_word = hit_word | way_rdata[w];
      end
    end
    hit_any    = |hit_vec;
    victim_sel = plru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_sel = WW'(w);
    end
  end

  plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk_i     (clk),
    .rst_ni    (rst),
    .rd_set_i  (cpu_idx),
    .victim_o  (plru_victim),
    .upd_en_i  (plru_upd),
    .upd_set_i ((state_q == ST_REFILL) ? idx_q : cpu_idx),
    .upd_way_i (plru_way)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    wait_d           = wait_q;
    tag_d            = tag_q;
    idx_d            = idx_q;
    victim_d         = victim_q;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = 32'h0;
    cache_inst_req   = 1'b0;
    cache_inst_size  = 2'b00;
    cache_inst_addr  = 32'h0;
    refill_we        = 1'b0;
    refill_last      = 1'b0;
    plru_upd         = 1'b0;
    plru_way         = hit_way;
    miss_inv         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_inst_req) begin
          if (cpu_inst_wr) begin
            cpu_inst_addr_ok = 1'b1;
            cpu_inst_data_ok = 1'b1;
          end else if (UNCACHED_EN && is_kseg1(cpu_inst_addr)) begin
            state_d = ST_UNCACHED;
            wait_d  = 1'b0;
          end else if (hit_any) begin
            cpu_inst_addr_ok = 1'b1;
            cpu_inst_data_ok = 1'b1;
            cpu_inst_rdata   = hit_word;
            plru_upd         = 1'b1;
          end else begin
            state_d  = ST_REFILL;
            tag_d    = cpu_tag;
            idx_d    = cpu_idx;
            victim_d = victim_sel;
            cnt_d    = '0;
            wait_d   = 1'b0;
            miss_inv = 1'b1;
          end
        end
      end
      ST_REFILL: begin
        cache_inst_req  = !wait_q;
        cache_inst_size = SIZE_WORD;
        cache_inst_addr = {tag_q, idx_q, cnt_q, 2'b00};
        if (cache_inst_req && cache_inst_addr_ok) wait_d = 1'b1;
        if (cache_inst_data_ok && (wait_q || cache_inst_addr_ok)) begin
          refill_we = 1'b1;
          wait_d    = 1'b0;
          if (cnt_q == '1) begin
            refill_last = 1'b1;
            plru_upd    = 1'b1;
            plru_way    = victim_q;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_UNCACHED: begin
        cache_inst_req  = !wait_q;
        cache_inst_size = cpu_inst_size;
        cache_inst_addr = cpu_inst_addr;
        if (cache_inst_req && cache_inst_addr_ok) wait_d = 1'b1;
        if (cache_inst_data_ok && (wait_q || cache_inst_addr_ok)) begin
          cpu_inst_addr_ok = 1'b1;
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = cache_inst_rdata;
          wait_d           = 1'b0;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are forced quiet while reset is held, independent of state.
    if (!rst) begin
      cpu_inst_addr_ok = 1'b0;
      cpu_inst_data_ok = 1'b0;
      cpu_inst_rdata   = 32'h0;
      cache_inst_req   = 1'b0;
      cache_inst_size  = 2'b00;
      cache_inst_addr  = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wait_q   <= 1'b0;
      tag_q    <= '0;
      idx_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) $onehot0(hit_vec));

endmodule

// File: tb/tb_icache_setassoc.sv
// Directed bench for icache_setassoc with a word-serial SRAM-like memory model.
module tb_icache_setassoc;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_inst_req, cpu_inst_wr;
  logic [1:0]  cpu_inst_size;
  logic [31:0] cpu_inst_addr, cpu_inst_wdata, cpu_inst_rdata;
  logic        cpu_inst_addr_ok, cpu_inst_data_ok;
  logic        cache_inst_req, cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr, cache_inst_wdata, cache_inst_rdata;
  logic        cache_inst_addr_ok, cache_inst_data_ok;

  int          checks = 0;
  int          failures = 0;
  int          stall_cycles = 0;
  int          nreq = 0;
  int          addr_unstable = 0;
  int          req_dropped = 0;
  logic [31:0] log_addr [256];
  logic [1:0]  log_size [256];

  always #5 clk = ~clk;

  icache_setassoc dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_inst_req       (cpu_inst_req),
    .cpu_inst_wr        (cpu_inst_wr),
    .cpu_inst_size      (cpu_inst_size),
    .cpu_inst_addr      (cpu_inst_addr),
    .cpu_inst_wdata     (cpu_inst_wdata),
    .cpu_inst_rdata     (cpu_inst_rdata),
    .cpu_inst_addr_ok   (cpu_inst_addr_ok),
    .cpu_inst_data_ok   (cpu_inst_data_ok),
    .cache_inst_req     (cache_inst_req),
    .cache_inst_wr      (cache_inst_wr),
    .cache_inst_size    (cache_inst_size),
    .cache_inst_addr    (cache_inst_addr),
    .cache_inst_wdata   (cache_inst_wdata),
    .cache_inst_rdata   (cache_inst_rdata),
    .cache_inst_addr_ok (cache_inst_addr_ok),
    .cache_inst_data_ok (cache_inst_data_ok)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory side: optional addr_ok stall, data one cycle after address acceptance.
  initial begin : mem_slave
    logic        pending;
    logic [31:0] pend_addr, seen_addr;
    int          stall;
    pending = 1'b0; pend_addr = '0; seen_addr = '0; stall = 0;
    cache_inst_addr_ok = 1'b0; cache_inst_data_ok = 1'b0; cache_inst_rdata = '0;
    forever begin
      @(negedge clk);
      cache_inst_addr_ok = 1'b0;
      cache_inst_data_ok = 1'b0;
      if (!rst) begin
        pending = 1'b0;
        stall   = 0;
      end else if (pending) begin
        cache_inst_data_ok = 1'b1;
        cache_inst_rdata   = mem_word(pend_addr);
        pending            = 1'b0;
      end else if (cache_inst_req) begin
        if (stall > 0 && cache_inst_addr != seen_addr) addr_unstable++;
        if (stall == 0) seen_addr = cache_inst_addr;
        if (stall < stall_cycles) begin
          stall++;
        end else begin
          cache_inst_addr_ok = 1'b1;
          pend_addr          = cache_inst_addr;
          log_addr[nreq]     = cache_inst_addr;
          log_size[nreq]     = cache_inst_size;
          nreq++;
          pending            = 1'b1;
          stall              = 0;
        end
      end else if (stall > 0) begin
        req_dropped++;
        stall = 0;
      end
    end
  end

  task automatic cpu_access(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                            output logic [31:0] d, output int cyc, output logic both);
    logic done;
    @(negedge clk);
    cpu_inst_req = 1'b1; cpu_inst_wr = wr; cpu_inst_size = sz; cpu_inst_addr = a;
    cyc = 0; d = '0; both = 1'b0; done = 1'b0;
    while (!done && cyc < 300) begin
      #1;
      cyc++;
      if (cpu_inst_data_ok) begin
        done = 1'b1;
        d    = cpu_inst_rdata;
        both = cpu_inst_addr_ok;
      end else begin
        @(negedge clk);
      end
    end
    check("txn_done", {31'b0, done}, 32'd1);
    @(posedge clk);
    #1;
    cpu_inst_req = 1'b0; cpu_inst_wr = 1'b0;
    $display("txn addr=%h wr=%0d rdata=%h cycles=%0d", a, wr, d, cyc);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] d;
    int          cyc, base;
    logic        both;
    cpu_inst_req = 1'b1; cpu_inst_wr = 1'b1; cpu_inst_size = 2'b10;
    cpu_inst_addr = 32'h0000_1000; cpu_inst_wdata = 32'h1234_5678;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cache_req", {31'b0, cache_inst_req}, 32'd0);
    check("rst_addr_ok", {31'b0, cpu_inst_addr_ok}, 32'd0);
    check("rst_data_ok", {31'b0, cpu_inst_data_ok}, 32'd0);
    check("rst_rdata", cpu_inst_rdata, 32'd0);
    @(negedge clk);
    cpu_inst_req = 1'b0; cpu_inst_wr = 1'b0;
    rst = 1'b1;

    // cold miss: 4-word refill then hit one cycle after the last memory word
    base = nreq;
    cpu_access(32'h0000_1004, 1'b0, 2'b10, d, cyc, both);
    check("cold_cycles", cyc, 32'd10);
    check("cold_rdata", d, mem_word(32'h0000_1004));
    check("cold_nreq", nreq - base, 32'd4);
    for (int i = 0; i < 4; i++) check("cold_addr", log_addr[base + i], 32'h0000_1000 + 32'(4 * i));
    check("cold_size", {30'b0, log_size[base]}, 32'd2);

    base = nreq;
    cpu_access(32'h0000_100C, 1'b0, 2'b10, d, cyc, both);
    check("hit_cycles", cyc, 32'd1);
    check("hit_both_ok", {31'b0, both}, 32'd1);
    check("hit_rdata", d, mem_word(32'h0000_100C));
    check("hit_nreq", nreq - base, 32'd0);

    // conflict in set 0: A=0x1000, B=0x2000, C=0x3000
    cpu_access(32'h0000_2000, 1'b0, 2'b10, d, cyc, both);
    check("fill_b_cycles", cyc, 32'd10);
    cpu_access(32'h0000_1000, 1'b0, 2'b10, d, cyc, both);
    check("touch_a_cycles", cyc, 32'd1);
    cpu_access(32'h0000_3000, 1'b0, 2'b10, d, cyc, both);
    check("miss_c_cycles", cyc, 32'd10);
    check("miss_c_rdata", d, mem_word(32'h0000_3000));
    cpu_access(32'h0000_1008, 1'b0, 2'b10, d, cyc, both);
    check("a_kept_cycles", cyc, 32'd1);
    check("a_kept_rdata", d, mem_word(32'h0000_1008));
    cpu_access(32'h0000_2004, 1'b0, 2'b10, d, cyc, both);
    check("b_evicted_cycles", cyc, 32'd10);

    // kseg1 bypass, twice
    base = nreq;
    cpu_access(32'hBFC0_0000, 1'b0, 2'b01, d, cyc, both);
    check("unc_cycles", cyc, 32'd3);
    check("unc_both_ok", {31'b0, both}, 32'd1);
    check("unc_rdata", d, mem_word(32'hBFC0_0000));
    check("unc_nreq", nreq - base, 32'd1);
    check("unc_addr", log_addr[base], 32'hBFC0_0000);
    check("unc_size", {30'b0, log_size[base]}, 32'd1);
    cpu_access(32'hBFC0_0000, 1'b0, 2'b01, d, cyc, both);
    check("unc2_cycles", cyc, 32'd3);
    check("unc2_nreq", nreq - base, 32'd2);

    // write completes as a no-op even on a cached address
    base = nreq;
    cpu_access(32'h0000_1000, 1'b1, 2'b10, d, cyc, both);
    check("wr_cycles", cyc, 32'd1);
    check("wr_both_ok", {31'b0, both}, 32'd1);
    check("wr_rdata", d, 32'd0);
    check("wr_nreq", nreq - base, 32'd0);

    // memory addr_ok stalled 5 cycles per word: 7 cycles per word
    stall_cycles = 5;
    base = nreq;
    cpu_access(32'h0000_2048, 1'b0, 2'b10, d, cyc, both);
    check("stall_cycles", cyc, 32'd30);
    check("stall_rdata", d, mem_word(32'h0000_2048));
    check("stall_nreq", nreq - base, 32'd4);
    check("stall_last_addr", log_addr[base + 3], 32'h0000_204C);
    check("stall_addr_stable", addr_unstable, 32'd0);
    check("stall_req_held", req_dropped, 32'd0);
    stall_cycles = 0;
    cpu_access(32'h0000_2040, 1'b0, 2'b10, d, cyc, both);
    check("stall_hit_cycles", cyc, 32'd1);
    check("stall_hit_rdata", d, mem_word(32'h0000_2040));

    // reset while the second refill word is being requested
    base = nreq;
    @(negedge clk);
    cpu_inst_req = 1'b1; cpu_inst_wr = 1'b0; cpu_inst_size = 2'b10; cpu_inst_addr = 32'h0000_4000;
    for (int i = 0; i < 60 && nreq < base + 2; i++) begin
      @(negedge clk);
      #1;
    end
    check("midrst_reached", nreq - base, 32'd2);
    rst = 1'b0;
    #1;
    check("midrst_cache_req", {31'b0, cache_inst_req}, 32'd0);
    check("midrst_addr_ok", {31'b0, cpu_inst_addr_ok}, 32'd0);
    check("midrst_data_ok", {31'b0, cpu_inst_data_ok}, 32'd0);
    check("midrst_rdata", cpu_inst_rdata, 32'd0);
    cpu_inst_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cpu_access(32'h0000_4000, 1'b0, 2'b10, d, cyc, both);
    check("postrst_cycles", cyc, 32'd10);
    check("postrst_rdata", d, mem_word(32'h0000_4000));
    cpu_access(32'h0000_1000, 1'b0, 2'b10, d, cyc, both);
    check("postrst_a_miss", cyc, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_setassoc.md
Name: icache_setassoc

Overview:
- Parametrised successor of the direct-mapped single-word instruction cache, placed between the MIPS core instruction port and the AXI bridge's SRAM-like instruction port.
- N-way set-associative, multi-word lines, tree pseudo-LRU replacement.
- Refills a line with sequential single-word reads.
- Optional uncached bypass for kseg1 (0xA000_0000–0xBFFF_FFFF).

Parameters:
INDEX_WIDTH, 6, set index bits (SETS = 2^INDEX_WIDTH)
OFFSET_WIDTH, 4, byte-offset bits; LINE_WORDS = 2^(OFFSET_WIDTH-2), minimum 2 words
WAYS, 2, associativity; legal values 1, 2, 4
UNCACHED_EN, 1, 1 = kseg1 addresses bypass the cache

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
cpu_inst_req  in  1  core request, held with addr stable until cpu_inst_addr_ok
cpu_inst_wr  in  1  write flag; writes are completed as no-ops
cpu_inst_size  in  2  access size, forwarded only on uncached reads
cpu_inst_addr  in  32  byte address
cpu_inst_wdata  in  32  ignored
cpu_inst_rdata  out  32  read data, valid when cpu_inst_data_ok
cpu_inst_addr_ok  out  1  request accepted
cpu_inst_data_ok  out  1  data returned
cache_inst_req  out  1  memory request
cache_inst_wr  out  1  tied 0
cache_inst_size  out  2  2'b10 on refill; cpu_inst_size on uncached
cache_inst_addr  out  32  memory word address
cache_inst_wdata  out  32  tied 0
cache_inst_rdata  in  32  memory read data
cache_inst_addr_ok  in  1  memory address accepted
cache_inst_data_ok  in  1  memory data valid

Behaviour:
- Address split: tag = addr[31:INDEX_WIDTH+OFFSET_WIDTH]; index = next INDEX_WIDTH bits; word = addr[OFFSET_WIDTH-1:2].
- Lookup:
  - All WAYS valid/tag compared combinationally.
  - At most one way hits; a multi-hit is an assertion failure.
- States:
  - IDLE
  - REFILL (refill in progress)
  - UNCACHED (single bypass read in progress)
- IDLE, cached address:
  - Hit with cpu_inst_req: cpu_inst_addr_ok = cpu_inst_data_ok = 1 in the same cycle; rdata = hit way's word; PLRU updated toward the hit way.
  - Miss: go to REFILL; latch tag, index and victim way; no ok signals this cycle.
- IDLE, kseg1 address with UNCACHED_EN=1: go to UNCACHED; the arrays are never consulted.
- IDLE, cpu_inst_wr=1: addr_ok = data_ok = 1 in the same cycle; rdata = 0; no state change.
- REFILL:
  - Word counter starts at 0 and reads words 0..LINE_WORDS-1 at {tag,index,cnt,2'b00}.
  - cache_inst_req is high until cache_inst_addr_ok and low while waiting for data_ok.
  - The next word's req rises the cycle after data_ok.
  - Each data_ok writes the word into the victim line.
  - On the last data_ok: set valid, write tag, update PLRU toward the victim, return to IDLE.
  - The held core request then hits on the next cycle, so miss latency = refill cycles + 1.
- UNCACHED:
  - One read at cpu_inst_addr with cpu_inst_size.
  - cpu_inst_addr_ok and cpu_inst_data_ok are both asserted in the cycle of cache_inst_data_ok; rdata = cache_inst_rdata.
  - No array update; return to IDLE.
- Victim selection:
  - Lowest-numbered invalid way in the set.
  - Otherwise the tree-PLRU victim (WAYS-1 bits per set).
  - WAYS=1 always selects way 0.
- Memory addr_ok and data_ok in the same cycle: the word is accepted and the counter advances.
- cpu_inst_req dropped mid-refill is illegal (the core never does it); the refill still completes.
- Reset (rst=0, any state):
  - state=IDLE, counter=0, all valid and PLRU bits cleared.
  - All outputs 0: cache_inst_req, cpu_inst_addr_ok, cpu_inst_data_ok, cpu_inst_rdata.
  - The AXI bridge shares this reset, so an in-flight refill is abandoned with no partial line valid.
- Refill data goes straight into the data array; the valid bit is set only on the last word, so a partial line is never visible.

Decomposition:
- Package icache_pkg: state encoding, KSEG1_BASE/KSEG1_MASK constants, SIZE_WORD = 2'b10.
- One sub-module, plru_tree: per-set PLRU storage, victim output, update-on-access input, parametrised by WAYS and SETS.

Test Plan:
- Cold read 0x0000_1004 (WAYS=2, LINE_WORDS=4): 4 memory reads at 0x1000, 0x1004, 0x1008, 0x100C. Core data_ok the cycle after the last memory data_ok, rdata = word at 0x1004.
- After that refill, read 0x0000_100C: addr_ok and data_ok in the same cycle, zero memory requests.
- Conflict: fill tags A then B into set 0, access A, then miss on C. The miss evicts B; a following A access hits and a B access misses.
- Read 0xBFC0_0000 with UNCACHED_EN=1: exactly one memory read with size = cpu size, data forwarded in the memory data_ok cycle. A repeat read misses again and issues another memory read.
- Memory addr_ok stalled 5 cycles per word: cache_inst_req is held high and addr is stable throughout; the line is filled correctly.
- rst asserted during the 2nd refill word: outputs go to 0 immediately. After release, the same address misses again (valid was cleared).
